// File: rtl/player_motion_ctl.sv
// Player sprite motion sequencer: walk, jump and gravity, stepped once per VGA frame.
// Optional airborne re-jump token enabled by defining PLAYER_DOUBLE_JUMP_EN.
module player_motion_ctl #(
  parameter int X_START  = 376,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 752,
  parameter int Y_GROUND = 500,
  parameter int STEP     = 4,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int V_MAX    = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        v_tick,
  input  logic        m_left,
  input  logic        m_right,
  input  logic        m_jump,
  input  logic        hold,
  output logic [11:0] xpos_player,
  output logic [11:0] ypos_player,
  output logic        airborne,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {GROUND = 2'd0, JUMP = 2'd1, FALL = 2'd2} st_t;

  localparam logic signed [12:0] XMIN_S = 13'(X_MIN);
  localparam logic signed [12:0] XMAX_S = 13'(X_MAX);
  localparam logic signed [12:0] YGND_S = 13'(Y_GROUND);
  localparam logic signed [12:0] STEP_S = 13'(STEP);
  localparam logic signed [12:0] GRAV_S = 13'(GRAVITY);
  localparam logic signed [12:0] VMAX_S = 13'(V_MAX);

  st_t         st_q, st_d;
  logic [1:0]  left_s, right_s, jump_s;
  logic        vt_q, vt_hist, tick;
  logic        l, r, j;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [4:0]  vy_q, vy_d;
  logic        armed_q, armed_d, air_d;
  logic        jump_go, land_go, rejump;
  logic signed [12:0] xs, ys, vys, vyn;

  assign l    = left_s[1];
  assign r    = right_s[1];
  assign j    = jump_s[1];
  assign tick = vt_q & ~vt_hist;

  // v_tick history resets high so a low vsync at release never looks like a rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_s  <= '0;
      right_s <= '0;
      jump_s  <= '0;
      vt_q    <= 1'b1;
      vt_hist <= 1'b1;
    end else begin
      left_s  <= {left_s[0], m_left};
      right_s <= {right_s[0], m_right};
      jump_s  <= {jump_s[0], m_jump};
      vt_q    <= v_tick;
      vt_hist <= vt_q;
    end
  end

`ifdef PLAYER_DOUBLE_JUMP_EN
  logic tok_q;
  assign rejump = j & armed_q & tok_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          tok_q <= 1'b1;
    else if (land_go)  tok_q <= 1'b1;
    else if (jump_go && st_q != GROUND) tok_q <= 1'b0;
  end
`else
  assign rejump = 1'b0;
`endif

  // State register (FSM state plus the datapath it steps)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= GROUND;
      x_q      <= 12'(X_START);
      y_q      <= 12'(Y_GROUND);
      vy_q     <= '0;
      armed_q  <= 1'b1;
      airborne <= 1'b0;
    end else begin
      st_q     <= st_d;
      x_q      <= x_d;
      y_q      <= y_d;
      vy_q     <= vy_d;
      armed_q  <= armed_d;
      airborne <= air_d;
    end
  end

  // Next-state and datapath step, evaluated only on an unheld frame tick
  always_comb begin
    st_d    = st_q;
    x_d     = x_q;
    y_d     = y_q;
    vy_d    = vy_q;
    armed_d = armed_q;
    jump_go = 1'b0;
    land_go = 1'b0;
    xs      = $signed({1'b0, x_q});
    ys      = $signed({1'b0, y_q});
    vys     = $signed({8'd0, vy_q});
    vyn     = '0;
    if (tick && !hold) begin
      if (l && !r) begin
        xs  = xs - STEP_S;
        x_d = (xs < XMIN_S) ? XMIN_S[11:0] : xs[11:0];
      end else if (r && !l) begin
        xs  = xs + STEP_S;
        x_d = (xs > XMAX_S) ? XMAX_S[11:0] : xs[11:0];
      end
      case (st_q)
        GROUND: if (j && armed_q) begin
          vy_d = 5'(JUMP_V); st_d = JUMP; jump_go = 1'b1;
        end
        JUMP: if (rejump) begin
          vy_d = 5'(JUMP_V); jump_go = 1'b1;
        end else if (ys < vys) begin
          y_d = '0; vy_d = '0; st_d = FALL;
        end else begin
          y_d = 12'(ys - vys);
          vyn = vys - GRAV_S;
          if (vyn <= 0) begin
            vy_d = '0; st_d = FALL;
          end else begin
            vy_d = vyn[4:0];
          end
        end
        FALL: begin
          vyn = vys + GRAV_S;
          if (vyn > VMAX_S) vyn = VMAX_S;
          // Landing wins over both the re-jump and a plain fall step
          if (ys + vyn >= YGND_S) begin
            y_d = YGND_S[11:0]; vy_d = '0; st_d = GROUND; land_go = 1'b1;
          end else if (rejump) begin
            vy_d = 5'(JUMP_V); st_d = JUMP; jump_go = 1'b1;
          end else begin
            y_d = 12'(ys + vyn); vy_d = vyn[4:0];
          end
        end
        default: st_d = GROUND;
      endcase
      if (jump_go)  armed_d = 1'b0;
      else if (!j)  armed_d = 1'b1;
    end
  end

  // Output logic
  always_comb begin
    air_d = (st_d != GROUND);
  end

  assign xpos_player = x_q;
  assign ypos_player = y_q;
  assign state       = st_q;

endmodule

// File: doc/player_motion_ctl.md
Name: player_motion_ctl

Overview:
- Per-frame sequencer for the player sprite: walking, jumping and gravity.
- Samples raw mouse-button levels; steps a ground/jump/fall FSM once per VGA frame.
- Outputs the xpos_player/ypos_player pair consumed by the player sprite and button-hit logic.
- Sits between MouseCtl and draw_player in the 40 MHz domain and replaces the simple left/right player controller.

Parameters:
- X_START, 376: reset x position (px).
- X_MIN, 0: left x limit.
- X_MAX, 752: right x limit (800 - 48 sprite width).
- Y_GROUND, 500: ground y (sprite top-left).
- STEP, 4: horizontal px per frame.
- JUMP_V, 12: initial upward velocity (px/frame).
- GRAVITY, 1: velocity change per frame.
- V_MAX, 15: fall velocity cap.

Ports:
- clk  in  1  pixel clock, 40 MHz
- rst  in  1  asynchronous, active-low reset
- v_tick  in  1  vsync from vga_timing; frame tick = its rising edge
- m_left  in  1  move-left level, asynchronous (from MouseCtl domain)
- m_right  in  1  move-right level, asynchronous
- m_jump  in  1  jump request level, asynchronous
- hold  in  1  freeze motion, e.g. button_pressed; synchronous
- xpos_player  out  12  player x, registered
- ypos_player  out  12  player y, registered
- airborne  out  1  high in JUMP or FALL
- state  out  2  FSM state: 0 GROUND, 1 JUMP, 2 FALL

Behaviour:
- Reset (rst=0, async):
  - xpos=X_START, ypos=Y_GROUND, vy=0, state=GROUND, airborne=0.
  - Synchronizers cleared; jump_armed=1; v_tick history=1, so no false tick right after reset.
- Input sync: m_left, m_right and m_jump each pass through a 2-flop synchronizer. v_tick is registered once.
- Tick: tick=1 for exactly one cycle when registered v_tick goes 0->1. Outputs update on the cycle after tick is asserted. There is no change between ticks.
- hold=1 on a tick cycle: the tick is ignored entirely. Position, vy and state are held, and jump_armed is unchanged.
- Horizontal, evaluated every tick in all states:
  - left only: x = max(x-STEP, X_MIN).
  - right only: x = min(x+STEP, X_MAX).
  - Both or neither: no change.
  - Arithmetic uses 13 bits signed so clamping never wraps.
- jump_armed: cleared when a jump starts; set on any tick where sync m_jump=0. Holding jump therefore does not auto-repeat.
- GROUND: on a tick with sync m_jump=1 and jump_armed=1: vy=JUMP_V, go to JUMP, ypos unchanged this tick.
- JUMP, each tick:
  - If y < vy: y=0, vy=0, go to FALL (ceiling clamp).
  - Otherwise: y -= vy, vy -= GRAVITY; if the new vy is 0, go to FALL.
- FALL, each tick:
  - vy = min(vy+GRAVITY, V_MAX), then y += vy.
  - If y+vy >= Y_GROUND: y=Y_GROUND, vy=0, go to GROUND (landing takes priority).
- Simultaneous jump and landing on the same tick: land only. A jump needs a later tick.
- airborne = (state != GROUND), registered.
- Reset mid-jump: immediate return to reset values.

Optional Feature:
- Macro PLAYER_DOUBLE_JUMP_EN.
- Defined: one airborne re-jump token, set on landing and at reset.
  - In JUMP or FALL, a tick with sync m_jump=1, jump_armed=1 and token=1 does: vy=JUMP_V, state=JUMP, token=0, jump_armed=0.
  - The re-jump takes priority over the normal JUMP/FALL step but not over landing.
- Not defined: jump requests are ignored while airborne; no token logic is synthesized.

Test Plan:
- Reset, then 3 ticks with m_right=1 -> xpos 376,380,384,388; ypos=500, state=0 throughout.
- xpos=748, m_right held 2 ticks -> 752, 752 (clamp). At xpos=2, m_left 1 tick -> 0.
- Jump from ground, then release m_jump:
  - tick1 -> state=1, vy=12.
  - Next 12 ticks -> ypos 488,477,...,422; then state=2.
  - 12 fall ticks -> ypos 423,...,500; state=0, airborne=0.
- m_jump held continuously through the landing -> no second jump until m_jump=0 for >=1 tick and then re-asserted.
- hold=1 during JUMP at ypos=455 for 5 ticks -> ypos and state unchanged; flight resumes when hold=0.
- rst pulsed low mid-FALL -> outputs return to 376/500/GROUND asynchronously, with no tick required.
